serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
Bit-serial WIDTH-bit adder/subtractor built around a single 1-bit full-adder slice and a carry flip-flop.
- Processes one bit per clock, LSB first, under a start/done handshake.
- Computes A+B, or A-B as A + ~B + 1.
- Sequential, area-minimal counterpart to the parallel add/sub datapath. Used where a multi-cycle latency is acceptable.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
sub    input   1      0 = add, 1 = subtract; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      high while operation in progress (RUN)
done   output  1      one-cycle pulse: result valid
sum    output  WIDTH  result; held until next accepted start
cout   output  1      final carry out (sub: 1 = no borrow, i.e. a >= b unsigned)
ovfl   output  1      two's-complement signed overflow

Behaviour:
- Reset: synchronous, active-high, one clock only. Sets state=IDLE; busy=0, done=0, sum=0, cout=0, ovfl=0; clears internal registers. Reset has priority over everything, including mid-RUN: the operation is aborted and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge latches a into shift reg A and b (sub ? ~b : b) into shift reg B.
  - Same edge: carry <= sub, bit counter <= 0, state <= RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - s = A[0]^B[0]^carry; c = majority(A[0], B[0], carry).
  - Result reg shifts right with s entering at MSB; A and B shift right; carry <= c; counter++.
  - On bit WIDTH-1: capture carry-in of that bit for ovfl. After WIDTH RUN cycles, state <= DONE.
- DONE:
  - done=1 for exactly one cycle.
  - sum = result reg, cout = final carry, ovfl = carry_into_MSB ^ final carry.
  - Next state IDLE.
- busy is 1 in RUN only; 0 in IDLE and DONE.
- Latency: start sampled at edge 0; busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1 (17 for WIDTH=16). Next start is accepted from the following IDLE cycle, so the minimum issue interval is WIDTH+2 cycles.
- start is ignored in RUN and DONE; it is neither queued nor latched.
- Operand changes on a, b, sub after acceptance have no effect.
- sum, cout and ovfl keep their last DONE values through IDLE and RUN. They update only in DONE, and are zeroed only by reset.
- Arithmetic is modulo 2^WIDTH. Subtraction uses carry-in=1 with inverted B, so b=0 subtract gives cout=1.

Optional Feature:
Macro: SERIAL_ADDSUB_SATURATE_EN
- Defined: when the signed overflow condition holds in DONE, sum is clamped. Positive overflow (a[MSB]=0) gives 0111..1; negative overflow gives 1000..0. ovfl still reports 1 and cout is unchanged.
- Undefined: sum is the wrapped modulo-2^WIDTH result; no clamping logic is present.

Test Plan:
1. Reset, then start, sub=0, a=0x0005, b=0x0003 -> busy for 16 cycles, done in cycle 17, sum=0x0008, cout=0, ovfl=0.
2. sub=0, a=0x7FFF, b=0x0001 -> sum=0x8000, ovfl=1, cout=0. With SERIAL_ADDSUB_SATURATE_EN: sum=0x7FFF, ovfl=1.
3. sub=1, a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovfl=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovfl=1 (saturated: 0x8000).
4. sub=0, a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovfl=0. Also sub=1, a=0x1234, b=0x0000 -> sum=0x1234, cout=1.
5. Start a=0x0010, b=0x0001. While busy, pulse start with a=0xFFFF, b=0xFFFF -> exactly one done, sum=0x0011. The second request is dropped and busy does not extend.
6. Start an operation, assert rst for one cycle at RUN cycle 7 -> next cycle busy=0, done=0, sum=0; no done pulse follows. A fresh start then completes normally with done in cycle 17.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor.
// A single 1-bit full-adder slice walks the operands LSB first, one bit per
// clock, under a start/done handshake. Subtraction is A + ~B + 1, where the
// "+1" is the initial carry-in.
// Optional build macro: SERIAL_ADDSUB_SATURATE_EN clamps the result on signed
// overflow (0111..1 for positive overflow, 1000..0 for negative overflow).
// Without the macro the result wraps modulo 2^WIDTH.

module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovfl
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

`ifdef SERIAL_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovfl;

    logic             w_sBit;
    logic             w_cBit;
    logic [WIDTH-1:0] w_resNext;
    logic             w_lastBit;
    logic             w_ovfl;

    // The full-adder slice. On the final bit, r_carry is the carry into the
    // MSB, so XOR with the carry out of the MSB gives signed overflow.
    // r_res holds the WIDTH-1 result bits already produced; together with the
    // current sum bit it forms the complete result on the final bit.
    always_comb begin
        w_sBit    = r_a[0] ^ r_b[0] ^ r_carry;
        w_cBit    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_resNext = {w_sBit, r_res};
        w_lastBit = (r_cnt == CW'(WIDTH - 1));
        w_ovfl    = r_carry ^ w_cBit;
    end

    // Control FSM and serial datapath; results are loaded on the edge that
    // enters DONE so they are valid while done is high and held afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovfl  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_resNext[WIDTH-1:1];
                    r_carry <= w_cBit;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_lastBit) begin
                        r_state <= S_DONE;
                        r_cout  <= w_cBit;
                        r_ovfl  <= w_ovfl;
`ifdef SERIAL_ADDSUB_SATURATE_EN
                        // r_a[0] is the original sign bit of A at this point;
                        // it tells which direction the overflow went.
                        if (w_ovfl) begin
                            r_sum <= r_a[0] ? SAT_NEG : SAT_POS;
                        end else begin
                            r_sum <= w_resNext;
                        end
`else
                        r_sum   <= w_resNext;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovfl = r_ovfl;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub (WIDTH=16).
// Expected values come from integer arithmetic on the operands, not from
// any bit-level model of the serial datapath.

module tb_serial_addsub;

    localparam int W = 16;
    localparam longint MOD  = 64'd1 << W;
    localparam longint HALF = 64'd1 << (W - 1);

`ifdef SERIAL_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] lastSum;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_sub   (sub),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovfl  (ovfl)
    );

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] es, output logic ec, output logic eo);
        longint ux, uy, sx, sy, ur, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= HALF) ? ux - MOD : ux;
        sy = (uy >= HALF) ? uy - MOD : uy;
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            ec = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            ec = (ur >= MOD);
        end
        es = ur[W-1:0];
        eo = (sr > HALF - 1) || (sr < -HALF);
        if (SAT && eo) es = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    endfunction

    // Issue one operation from an IDLE cycle and watch it until done (bounded).
    // Operands are scrambled right after acceptance. Returns observed values
    // only; comparisons live in the tests.
    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] gs, output logic gc, output logic go,
                         output int doneCyc, output int busyCnt, output logic [W-1:0] runSum);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        sub     = 1'($urandom);
        doneCyc = -1;
        busyCnt = 0;
        gs      = 'x;
        gc      = 1'bx;
        go      = 1'bx;
        runSum  = 'x;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy) busyCnt++;
            if (cyc == 2) runSum = sum;
            if (done) begin
                doneCyc = cyc;
                gs = sum;
                gc = cout;
                go = ovfl;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
        end
        total++;
        if (sum !== '0 || cout !== 1'b0 || ovfl !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out: sum=%h cout=%b ovfl=%b, want 0000 0 0", sum, cout, ovfl);
        end
        lastSum = '0;
    endtask

    task automatic test_directed();
        vec_t v[9];
        logic [W-1:0] gs, rs;
        logic gc, go;
        int dc, bc;
        v[0] = '{1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
        v[1] = '{1'b0, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        v[2] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
        v[3] = '{1'b1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        v[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        v[5] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0};
        v[6] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0};
        v[7] = '{1'b1, 16'h0000, 16'h8000, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
        v[8] = '{1'b0, 16'h8000, 16'hFFFF, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].s, v[i].a, v[i].b, gs, gc, go, dc, bc, rs);
            total++;
            if (dc !== W + 1 || bc !== W) begin
                bad++;
                $display("[TB] FAIL dir%0d_timing: done_cycle=%0d busy_cycles=%0d, want %0d %0d", i, dc, bc, W + 1, W);
            end
            total++;
            if (gs !== v[i].es || gc !== v[i].ec || go !== v[i].eo) begin
                bad++;
                $display("[TB] FAIL dir%0d_result: sum=%h cout=%b ovfl=%b, want %h %b %b",
                         i, gs, gc, go, v[i].es, v[i].ec, v[i].eo);
            end
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== v[i].es) begin
                bad++;
                $display("[TB] FAIL dir%0d_after: done=%b busy=%b sum=%h, want 0 0 %h", i, done, busy, sum, v[i].es);
            end
            lastSum = v[i].es;
        end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] gs, rs, es;
        logic gc, go, ec, eo;
        int dc, bc, dones, busies;
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL abort_pre: busy=%b at run cycle 7, want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovfl !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_state: busy=%b done=%b sum=%h cout=%b ovfl=%b, want 0 0 0000 0 0",
                     busy, done, sum, cout, ovfl);
        end
        dones = 0;
        busies = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (done) dones++;
            if (busy) busies++;
            @(posedge clk);
            #1;
        end
        total++;
        if (dones !== 0 || busies !== 0) begin
            bad++;
            $display("[TB] FAIL abort_quiet: dones=%0d busy_cycles=%0d, want 0 0", dones, busies);
        end
        model(1'b1, 16'h4321, 16'h1234, es, ec, eo);
        do_op(1'b1, 16'h4321, 16'h1234, gs, gc, go, dc, bc, rs);
        total++;
        if (dc !== W + 1 || gs !== es || gc !== ec || go !== eo || rs !== '0) begin
            bad++;
            $display("[TB] FAIL abort_fresh: cyc=%0d sum=%h cout=%b ovfl=%b runsum=%h, want %0d %h %b %b 0000",
                     dc, gs, gc, go, rs, W + 1, es, ec, eo);
        end
        @(posedge clk);
        #1;
        lastSum = es;
    endtask

    task automatic test_start_ignored();
        int dones, busies;
        logic [W-1:0] gs;
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h0010;
        b     = 16'h0001;
        @(posedge clk);
        #1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        start = 1'b0;
        dones = 0;
        busies = 0;
        gs = 'x;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy) busies++;
            if (done) begin
                dones++;
                gs = sum;
            end
            start = (cyc == 3) || (cyc == 9) || done;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        total++;
        if (dones !== 1 || busies !== W) begin
            bad++;
            $display("[TB] FAIL ignore_count: dones=%0d busy_cycles=%0d, want 1 %0d", dones, busies, W);
        end
        total++;
        if (gs !== 16'h0011) begin
            bad++;
            $display("[TB] FAIL ignore_sum: sum=%h, want 0011", gs);
        end
        lastSum = 16'h0011;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y, es, gs, rs;
        logic s, ec, eo, gc, go;
        int dc, bc;
        logic [W-1:0] corner[5];
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'h7FFF;
        corner[3] = 16'h8000;
        corner[4] = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
            s = 1'($urandom);
            model(s, x, y, es, ec, eo);
            do_op(s, x, y, gs, gc, go, dc, bc, rs);
            total++;
            if (dc !== W + 1 || bc !== W || rs !== lastSum) begin
                bad++;
                $display("[TB] FAIL rand%0d_timing: cyc=%0d busy=%0d runsum=%h, want %0d %0d %h",
                         i, dc, bc, rs, W + 1, W, lastSum);
            end
            total++;
            if (gs !== es || gc !== ec || go !== eo) begin
                bad++;
                $display("[TB] FAIL rand%0d_result: sub=%b a=%h b=%h sum=%h cout=%b ovfl=%b, want %h %b %b",
                         i, s, x, y, gs, gc, go, es, ec, eo);
            end
            lastSum = es;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        $display("[TB] serial_addsub bench start, saturate=%0d", SAT);
        test_reset();
        test_directed();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
